// File: rtl/xprova_pkg.sv
// Shared helpers for the xprova synchroniser cells: counter sizing and
// parameter legality checks used at elaboration time.
package xprova_pkg;

  localparam int MIN_WIDTH  = 1;
  localparam int MIN_STAGES = 2;
  localparam int MIN_SETTLE = 1;

  // Ceiling log2 for n >= 1; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH);
  endfunction

  function automatic bit stages_ok(input int s);
    return (s >= MIN_STAGES);
  endfunction

  function automatic bit settle_ok(input int s);
    return (s >= MIN_SETTLE);
  endfunction

endpackage

// File: rtl/dffx_settle_cnt.sv
// Saturating stability counter: SETTLED asserts once Q has held for SETTLE
// consecutive edges; clr or a pending Q change restarts the count.
module dffx_settle_cnt
  import xprova_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic CK,
  input  logic RS,
  input  logic clr,
  input  logic q_changed,
  output logic SETTLED
);

  localparam int CW = (clog2(SETTLE + 1) < 1) ? 1 : clog2(SETTLE + 1);
  localparam logic [CW-1:0] CMAX = CW'(SETTLE);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr || q_changed) begin
      cnt_nxt = '0;
    end else if (cnt != CMAX) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // SETTLED is a flop fed from the next count, so it lines up with cnt.
  always_ff @(posedge CK or negedge RS) begin
    if (!RS) begin
      cnt     <= '0;
      SETTLED <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      SETTLED <= (cnt_nxt == CMAX);
    end
  end

endmodule

// File: rtl/dffx_sync.sv
// WIDTH-bit, STAGES-deep synchroniser chain with optional metastability
// injection on the first stage and an output settle tracker.
module dffx_sync
  import xprova_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter int               STAGES  = 2,
  parameter int               INJECT  = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               SETTLE  = 4
) (
  input  logic             CK,
  input  logic             RS,
  input  logic             EN,
  input  logic             ST,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] V,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] T,
  output logic [WIDTH-1:0] M,
  output logic             SETTLED
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("dffx_sync: WIDTH must be >= 1");
  end
  if (!stages_ok(STAGES)) begin : g_bad_stages
    $error("dffx_sync: STAGES must be >= 2");
  end
  if (!settle_ok(SETTLE)) begin : g_bad_settle
    $error("dffx_sync: SETTLE must be >= 1");
  end

  logic [WIDTH-1:0] dprev;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] m_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] taps [STAGES];
  logic             q_changed;

  assign T = (D ^ dprev) & {WIDTH{EN}};

  // Transitioning bits take the free resolution value V on capture.
  for (genvar b = 0; b < WIDTH; b++) begin : g_inj
    if (INJECT != 0) begin : g_on
      assign cap[b]   = T[b] ? V[b] : D[b];
      assign m_nxt[b] = T[b];
    end else begin : g_off
      assign cap[b]   = D[b];
      assign m_nxt[b] = 1'b0;
    end
  end

  always_ff @(posedge CK or negedge RS) begin
    if (!RS) begin
      dprev <= RST_VAL;
      M     <= '0;
    end else if (ST) begin
      dprev <= '1;
      M     <= '0;
    end else if (EN) begin
      dprev <= D;
      M     <= m_nxt;
    end else begin
      M     <= '0;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] q;

    if (k == 0) begin : g_first
      assign d_in = cap;
    end else begin : g_next
      assign d_in = taps[k-1];
    end

    always_ff @(posedge CK or negedge RS) begin
      if (!RS) begin
        q <= RST_VAL;
      end else if (ST) begin
        q <= '1;
      end else if (EN) begin
        q <= d_in;
      end
    end

    assign taps[k] = q;
  end

  assign Q = taps[STAGES-1];

  // Next Q depends only on registered stages and ST/EN, never on D.
  always_comb begin
    q_nxt = Q;
    if (ST) begin
      q_nxt = '1;
    end else if (EN) begin
      q_nxt = taps[STAGES-2];
    end
  end

  assign q_changed = (q_nxt != Q);

  dffx_settle_cnt #(
    .SETTLE(SETTLE)
  ) u_settle (
    .CK       (CK),
    .RS       (RS),
    .clr      (ST),
    .q_changed(q_changed),
    .SETTLED  (SETTLED)
  );

endmodule

// File: tb/tb_dffx_sync.sv
// Scoreboard bench for dffx_sync: one plain chain and one injecting chain
// driven by the same stimulus and compared against a cycle model.
module tb_dffx_sync;

  localparam int STAGES = 2;
  localparam int SETTLE = 3;
  localparam logic [3:0] RV [2] = '{4'h0, 4'h9};
  localparam int INJ [2] = '{0, 1};

  logic       CK = 1'b0;
  logic       RS;
  logic       EN;
  logic       ST;
  logic [3:0] D;
  logic [3:0] V;
  logic [3:0] Q0, T0, M0, Q1, T1, M1;
  logic       S0, S1;

  always #5 CK = ~CK;

  dffx_sync #(.WIDTH(4), .STAGES(STAGES), .INJECT(0), .RST_VAL(4'h0), .SETTLE(SETTLE)) u_dut0 (
    .CK(CK), .RS(RS), .EN(EN), .ST(ST), .D(D), .V(V),
    .Q(Q0), .T(T0), .M(M0), .SETTLED(S0)
  );

  dffx_sync #(.WIDTH(4), .STAGES(STAGES), .INJECT(1), .RST_VAL(4'h9), .SETTLE(SETTLE)) u_dut1 (
    .CK(CK), .RS(RS), .EN(EN), .ST(ST), .D(D), .V(V),
    .Q(Q1), .T(T1), .M(M1), .SETTLED(S1)
  );

  typedef struct {
    logic [3:0] q0, m0, q1, m1;
    logic       s0, s1;
  } exp_t;

  exp_t sb [$];

  int n_chk = 0;
  int n_err = 0;

  logic [3:0] m_stg   [2][STAGES];
  logic [3:0] m_dprev [2];
  logic [3:0] m_m     [2];
  int         m_cnt   [2];
  logic [3:0] t_seen0, t_seen1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < STAGES; k++) m_stg[i][k] = RV[i];
      m_dprev[i] = RV[i];
      m_m[i]     = 4'h0;
      m_cnt[i]   = 0;
    end
  endtask

  function automatic logic [3:0] model_t(input int i);
    return (D ^ m_dprev[i]) & {4{EN}};
  endfunction

  task automatic model_edge(input int i);
    logic [3:0] t, qc, qn;
    t  = model_t(i);
    qc = m_stg[i][STAGES-1];
    if (ST) begin
      for (int k = 0; k < STAGES; k++) m_stg[i][k] = 4'hF;
      m_dprev[i] = 4'hF;
      m_m[i]     = 4'h0;
    end else if (EN) begin
      for (int k = STAGES - 1; k > 0; k--) m_stg[i][k] = m_stg[i][k-1];
      m_stg[i][0] = (INJ[i] != 0) ? ((D & ~t) | (V & t)) : D;
      m_dprev[i]  = D;
      m_m[i]      = (INJ[i] != 0) ? t : 4'h0;
    end else begin
      m_m[i] = 4'h0;
    end
    qn = m_stg[i][STAGES-1];
    if (ST || (qn != qc)) m_cnt[i] = 0;
    else if (m_cnt[i] < SETTLE) m_cnt[i] = m_cnt[i] + 1;
  endtask

  // Drive one cycle of stimulus, queue the model's post-edge outputs,
  // then compare the DUT against the popped entry after the edge.
  task automatic step(input logic [3:0] d, input logic [3:0] v, input logic en, input logic st);
    exp_t e;
    D = d; V = v; EN = en; ST = st;
    #1;
    t_seen0 = T0;
    t_seen1 = T1;
    check("t0", T0, model_t(0));
    check("t1", T1, model_t(1));
    model_edge(0);
    model_edge(1);
    e.q0 = m_stg[0][STAGES-1]; e.m0 = m_m[0]; e.s0 = (m_cnt[0] == SETTLE);
    e.q1 = m_stg[1][STAGES-1]; e.m1 = m_m[1]; e.s1 = (m_cnt[1] == SETTLE);
    sb.push_back(e);
    @(posedge CK);
    #1;
    check("sb_depth", sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("q0", Q0, e.q0);
      check("m0", M0, e.m0);
      check("s0", S0, e.s0);
      check("q1", Q1, e.q1);
      check("m1", M1, e.m1);
      check("s1", S1, e.s1);
    end
  endtask

  initial begin
    RS = 1'b0; EN = 1'b1; ST = 1'b0; D = 4'h3; V = 4'h0;
    model_reset();
    @(posedge CK);
    @(posedge CK);
    #1;
    check("rst_q0", Q0, 4'h0);
    check("rst_q1", Q1, 4'h9);
    check("rst_m1", M1, 4'h0);
    check("rst_s0", S0, 1'b0);
    check("rst_t0", T0, 4'h3);
    check("rst_t1", T1, 4'hA);
    RS = 1'b1;

    // Plain chain: single-cycle T, two-edge latency, settle after three.
    step(4'hA, 4'h0, 1'b1, 1'b0);
    check("p_t_first", t_seen0, 4'hA);
    check("p_q_e1", Q0, 4'h0);
    step(4'hA, 4'h0, 1'b1, 1'b0);
    check("p_t_second", t_seen0, 4'h0);
    check("p_q_e2", Q0, 4'hA);
    step(4'hA, 4'h0, 1'b1, 1'b0);
    step(4'hA, 4'h0, 1'b1, 1'b0);
    check("p_settle_e4", S0, 1'b0);
    step(4'hA, 4'h0, 1'b1, 1'b0);
    check("p_settle_e5", S0, 1'b1);
    check("p_m0", M0, 4'h0);

    // Injection with V=0: true value arrives one enabled edge late.
    for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 1'b1, 1'b0);
    step(4'h5, 4'h0, 1'b1, 1'b0);
    check("i5_m_e1", M1, 4'h5);
    step(4'h5, 4'h0, 1'b1, 1'b0);
    check("i5_m_e2", M1, 4'h0);
    check("i5_q_e2", Q1, 4'h0);
    step(4'h5, 4'h0, 1'b1, 1'b0);
    check("i5_q_e3", Q1, 4'h5);

    // Injection with V=6: Q shows the resolved value for one cycle.
    for (int i = 0; i < 3; i++) step(4'h0, 4'h0, 1'b1, 1'b0);
    step(4'hF, 4'h6, 1'b1, 1'b0);
    check("i6_m_e1", M1, 4'hF);
    step(4'hF, 4'h6, 1'b1, 1'b0);
    check("i6_q_e2", Q1, 4'h6);
    check("i6_s_e2", S1, 1'b0);
    step(4'hF, 4'h6, 1'b1, 1'b0);
    check("i6_q_e3", Q1, 4'hF);

    // Synchronous set wins over enable; T then compares against all-ones.
    step(4'h3, 4'h0, 1'b1, 1'b1);
    check("st_q0", Q0, 4'hF);
    check("st_q1", Q1, 4'hF);
    check("st_m1", M1, 4'h0);
    check("st_s0", S0, 1'b0);
    step(4'h3, 4'h0, 1'b1, 1'b0);
    check("st_t0", t_seen0, 4'hC);
    check("st_t1", t_seen1, 4'hC);

    // Enable low: D toggling is invisible, Q holds, settle keeps counting.
    for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 4'h1 : 4'h2, 4'hF, 1'b0, 1'b0);
    check("en0_q0", Q0, 4'hF);
    check("en0_s0", S0, 1'b1);
    check("en0_m1", M1, 4'h0);

    // Asynchronous reset in the middle of a transfer.
    for (int i = 0; i < 5; i++) step(4'h0, 4'h0, 1'b1, 1'b0);
    step(4'h5, 4'h0, 1'b1, 1'b0);
    check("pre_rst_m1", M1, 4'h5);
    check("pre_rst_s0", S0, 1'b1);
    #2;
    RS = 1'b0;
    model_reset();
    #1;
    check("mid_rst_q0", Q0, 4'h0);
    check("mid_rst_q1", Q1, 4'h9);
    check("mid_rst_m1", M1, 4'h0);
    check("mid_rst_s0", S0, 1'b0);
    check("mid_rst_s1", S1, 1'b0);
    check("mid_rst_t0", T0, 4'h5);
    check("mid_rst_t1", T1, 4'hC);
    @(posedge CK);
    #1;
    RS = 1'b1;
    step(4'h5, 4'h0, 1'b1, 1'b0);
    step(4'h5, 4'h0, 1'b1, 1'b0);
    check("post_rst_q0", Q0, 4'h5);

    // Mixed traffic against the model.
    for (int i = 0; i < 40; i++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
